merge_pass_scheduler: RTL and testbench
=======================================

Name: merge_pass_scheduler

Overview:
Sequences a full multi-pass merge sort over the ping-pong tuple banks. It drives the merge phase engine one pass at a time, doubling the run width each pass and swapping source and destination banks. It stops when a single sorted run covers all entries. It also arbitrates bank-port ownership between the loader, the merge phase and the drain reader, and it detects hung passes with a watchdog.

Parameters:
START_WIDTH, 16, run length (entries) already sorted by the loader; initial merge width
MAX_PASSES, 16, pass limit; exceeding it is an error
TIMEOUT_CYCLES, 1048576, max cycles a single pass may run before error
CNT_WIDTH, `BANK_ADDR_WIDTH+1, width of entry count and merge width

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
start_in  input  1  one-cycle request to begin a sort; sampled only in IDLE, DONE, ERROR
num_entries_in  input  CNT_WIDTH  entries to sort; latched on accepted start
abort_in  input  1  synchronous abort from any state
phase_done_in  input  1  merge phase engine reports current pass complete
phase_start_out  output  1  one-cycle pulse launching a pass
phase_en_out  output  1  enable to merge phase engine for the whole pass
merge_width_out  output  CNT_WIDTH  current input run width
src_bank_out  output  1  bank read this pass; destination is its complement
pass_count_out  output  5  passes completed
owner_out  output  2  bank-port owner: 0 LOADER, 1 MERGE, 2 DRAIN
result_bank_out  output  1  bank holding the sorted result; valid while done_out
busy_out  output  1  high in CHECK, ISSUE, RUN
done_out  output  1  sort complete; held until next accepted start
error_out  output  1  timeout or pass-limit error; held until next accepted start

Behaviour:
- Reset (async assert, sync deassert): state IDLE; all outputs 0; merge_width_out = START_WIDTH; owner_out = LOADER.
- States: IDLE, CHECK, ISSUE, RUN, DONE, ERROR.
- IDLE/DONE/ERROR + start_in:
  - latch n = num_entries_in;
  - width = START_WIDTH, src = 0, pass = 0;
  - clear done and error;
  - go to CHECK.
- CHECK:
  - if width >= n, go to DONE with result_bank = src (this also covers n = 0 and n <= START_WIDTH with 0 passes);
  - else if pass == MAX_PASSES, go to ERROR;
  - else go to ISSUE.
- ISSUE: phase_start_out = 1 for exactly this cycle; phase_en_out = 1; watchdog = 0; go to RUN.
- RUN:
  - phase_en_out = 1; watchdog increments each cycle.
  - On phase_done_in: width <<= 1 (saturate at all-ones); src toggles; pass += 1; go to CHECK.
  - If watchdog reaches TIMEOUT_CYCLES-1 without done, go to ERROR.
  - If phase_done_in and timeout occur in the same cycle, done wins.
- phase_done_in outside RUN is ignored.
- Latency: start accepted at edge t, phase_start_out high in cycle t+2. Pass-to-pass gap is 2 cycles (CHECK, ISSUE) after the done edge.
- start_in while busy_out is ignored; no re-latch.
- abort_in in any state: next state IDLE; phase_en_out drops the following cycle; done and error are cleared. abort_in has priority over start_in and phase_done_in.
- owner_out:
  - MERGE in CHECK/ISSUE/RUN;
  - DRAIN in DONE;
  - LOADER in IDLE/ERROR.
- owner_out changes are registered so owner never glitches mid-cycle.
- phase_en_out is low in all non-busy states.
- Reset mid-RUN: immediate return to reset values; no pending pass is resumed.

Decomposition:
- Shared package holds:
  - bank_owner_e enum {OWNER_LOADER, OWNER_MERGE, OWNER_DRAIN};
  - sched_state_e enum;
  - START_WIDTH default constant;
  - CNT_WIDTH derivation from `BANK_ADDR_WIDTH.
- One natural sub-module: pass_watchdog (clear/enable/expired counter, TIMEOUT_CYCLES parameter).

Test Plan:
- n=64, START_WIDTH=16: 2 passes (widths 16, 32), src 0→1→0, pass_count=2, result_bank=0, done_out high, owner=DRAIN.
- n=100: 3 passes (16, 32, 64), result_bank=1. phase_start_out pulses exactly 3 times, each 2 cycles after the preceding done edge (first 2 cycles after start).
- n=16 and n=0: no phase_start_out; done_out high 2 cycles after start; pass_count=0, result_bank=0.
- Hold phase_done_in low in RUN with TIMEOUT_CYCLES=32: error_out high 32 cycles after ISSUE, phase_en_out low, owner=LOADER; a new start clears error.
- abort_in during pass 2 RUN, asserted together with phase_done_in: next state IDLE, pass_count not incremented, phase_en_out low next cycle. reset_n pulsed mid-RUN: all outputs at reset values asynchronously.
- start_in pulses during RUN, and phase_done_in pulses in IDLE: no state change and no counter change.

Source files
------------

// File: rtl/merge_pass_scheduler_pkg.sv
// Shared types and constants for the multi-pass merge sort scheduler.
// Bank address width comes from the build; a default is supplied for standalone use.
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 10
`endif

package merge_pass_scheduler_pkg;

   localparam int SCHED_BANK_ADDR_WIDTH = `BANK_ADDR_WIDTH;
   // Counts must hold the full bank depth, hence one bit more than the address.
   localparam int SCHED_CNT_WIDTH       = SCHED_BANK_ADDR_WIDTH + 1;
   localparam int SCHED_START_WIDTH     = 16;

   typedef enum logic [1:0] {
      OWNER_LOADER = 2'd0,
      OWNER_MERGE  = 2'd1,
      OWNER_DRAIN  = 2'd2
   } bank_owner_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_ISSUE = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERROR = 3'd5
   } sched_state_e;

endpackage

// File: rtl/merge_pass_scheduler_watchdog.sv
// Per-pass watchdog: counts enabled cycles since the last clear and flags
// when the pass has had TIMEOUT_CYCLES enabled cycles.
module pass_watchdog #(
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i && (count_q != LAST)) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = en_i && (count_q == LAST);

endmodule

// File: rtl/merge_pass_scheduler.sv
// Sequences merge passes over the ping-pong banks, doubling run width each pass,
// arbitrates bank ownership, and aborts hung passes via the watchdog.
module merge_pass_scheduler
   import merge_pass_scheduler_pkg::*;
#(
   parameter int START_WIDTH    = SCHED_START_WIDTH,
   parameter int MAX_PASSES     = 16,
   parameter int TIMEOUT_CYCLES = 1048576,
   parameter int CNT_WIDTH      = SCHED_CNT_WIDTH
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 start_in,
   input  logic [CNT_WIDTH-1:0] num_entries_in,
   input  logic                 abort_in,
   input  logic                 phase_done_in,
   output logic                 phase_start_out,
   output logic                 phase_en_out,
   output logic [CNT_WIDTH-1:0] merge_width_out,
   output logic                 src_bank_out,
   output logic [4:0]           pass_count_out,
   output logic [1:0]           owner_out,
   output logic                 result_bank_out,
   output logic                 busy_out,
   output logic                 done_out,
   output logic                 error_out,
   output logic [2:0]           dbg_state_out
);

   // Handshake: start_in is a one-cycle request honoured only when not busy;
   // phase_done_in is a one-cycle completion honoured only in RUN; abort_in wins over both.

   sched_state_e         state_q, state_d;
   logic [CNT_WIDTH-1:0] n_q, n_d;
   logic [CNT_WIDTH-1:0] width_q, width_d;
   logic                 src_q, src_d;
   logic [4:0]           pass_q, pass_d;
   logic                 result_q, result_d;
   bank_owner_e          owner_q, owner_d;
   logic                 wd_expired;

   pass_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_i    (clock),
      .rst_ni   (reset_n),
      .clear_i  (state_q == ST_CHECK),
      .en_i     (phase_en_out),
      .expired_o(wd_expired)
   );

   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      width_d  = width_q;
      src_d    = src_q;
      pass_d   = pass_q;
      result_d = result_q;
      if (abort_in) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (start_in) begin
                  n_d     = num_entries_in;
                  width_d = CNT_WIDTH'(START_WIDTH);
                  src_d   = 1'b0;
                  pass_d  = '0;
                  state_d = ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (width_q >= n_q) begin
                  result_d = src_q;
                  state_d  = ST_DONE;
               end else if (pass_q == 5'(MAX_PASSES)) begin
                  state_d = ST_ERROR;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
            ST_ISSUE: state_d = ST_RUN;
            ST_RUN: begin
               if (phase_done_in) begin
                  // Width saturates at all-ones so it always ends up >= any n.
                  width_d = width_q[CNT_WIDTH-1] ? '1 : {width_q[CNT_WIDTH-2:0], 1'b0};
                  src_d   = ~src_q;
                  pass_d  = pass_q + 5'd1;
                  state_d = ST_CHECK;
               end else if (wd_expired) begin
                  state_d = ST_ERROR;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      owner_d = OWNER_LOADER;
      case (state_d)
         ST_CHECK, ST_ISSUE, ST_RUN: owner_d = OWNER_MERGE;
         ST_DONE:                    owner_d = OWNER_DRAIN;
         default:                    owner_d = OWNER_LOADER;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         n_q      <= '0;
         width_q  <= CNT_WIDTH'(START_WIDTH);
         src_q    <= 1'b0;
         pass_q   <= '0;
         result_q <= 1'b0;
         owner_q  <= OWNER_LOADER;
      end else begin
         state_q  <= state_d;
         n_q      <= n_d;
         width_q  <= width_d;
         src_q    <= src_d;
         pass_q   <= pass_d;
         result_q <= result_d;
         owner_q  <= owner_d;
      end
   end

   assign phase_start_out = (state_q == ST_ISSUE);
   assign phase_en_out    = (state_q == ST_ISSUE) || (state_q == ST_RUN);
   assign busy_out        = (state_q == ST_CHECK) || phase_en_out;
   assign done_out        = (state_q == ST_DONE);
   assign error_out       = (state_q == ST_ERROR);
   assign merge_width_out = width_q;
   assign src_bank_out    = src_q;
   assign pass_count_out  = pass_q;
   assign result_bank_out = result_q;
   assign owner_out       = owner_q;
   assign dbg_state_out   = state_q;

endmodule

// File: tb/tb_merge_pass_scheduler.sv
// Bench for merge_pass_scheduler: directed scenarios plus randomized sorts,
// checked every cycle against a pass-level behavioural model.
module tb_merge_pass_scheduler;
   import merge_pass_scheduler_pkg::*;

   localparam int SW   = 16;
   localparam int MP   = 3;
   localparam int TO   = 32;
   localparam int CW   = SCHED_CNT_WIDTH;
   localparam int ALL1 = (1 << CW) - 1;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          start_in = 1'b0;
   logic [CW-1:0] num_entries_in = '0;
   logic          abort_in = 1'b0;
   logic          phase_done_in = 1'b0;
   logic          phase_start_out, phase_en_out, src_bank_out, result_bank_out;
   logic          busy_out, done_out, error_out;
   logic [CW-1:0] merge_width_out;
   logic [4:0]    pass_count_out;
   logic [1:0]    owner_out;
   logic [2:0]    dbg_state_out;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   merge_pass_scheduler #(
      .START_WIDTH(SW), .MAX_PASSES(MP), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
   ) dut (
      .clock(clock), .reset_n(reset_n), .start_in(start_in),
      .num_entries_in(num_entries_in), .abort_in(abort_in),
      .phase_done_in(phase_done_in), .phase_start_out(phase_start_out),
      .phase_en_out(phase_en_out), .merge_width_out(merge_width_out),
      .src_bank_out(src_bank_out), .pass_count_out(pass_count_out),
      .owner_out(owner_out), .result_bank_out(result_bank_out),
      .busy_out(busy_out), .done_out(done_out), .error_out(error_out),
      .dbg_state_out(dbg_state_out)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
   endtask

   // Pass-level model: a sort is either inactive or at some step since its last
   // kick (start or pass completion): step 0 decides, step 1 launches, 2+ runs.
   bit m_active, m_done, m_err, m_src, m_result;
   int m_n, m_w, m_pass, m_step;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_active <= 0; m_done <= 0; m_err <= 0; m_src <= 0; m_result <= 0;
         m_n <= 0; m_w <= SW; m_pass <= 0; m_step <= 0;
      end else if (abort_in) begin
         m_active <= 0; m_done <= 0; m_err <= 0;
      end else if (!m_active) begin
         if (start_in) begin
            m_n <= int'(num_entries_in); m_w <= SW; m_src <= 0; m_pass <= 0;
            m_done <= 0; m_err <= 0; m_active <= 1; m_step <= 0;
         end
      end else if (m_step == 0) begin
         if (m_w >= m_n) begin
            m_active <= 0; m_done <= 1; m_result <= m_src;
         end else if (m_pass == MP) begin
            m_active <= 0; m_err <= 1;
         end else begin
            m_step <= 1;
         end
      end else if (m_step >= 2 && phase_done_in) begin
         m_w <= (m_w * 2 > ALL1) ? ALL1 : m_w * 2;
         m_src <= ~m_src; m_pass <= m_pass + 1; m_step <= 0;
      end else if (m_step >= TO) begin
         // the pass has had TO enable cycles (launch plus run) with no completion
         m_active <= 0; m_err <= 1;
      end else begin
         m_step <= m_step + 1;
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         check("phase_start", phase_start_out, m_active && m_step == 1);
         check("phase_en", phase_en_out, m_active && m_step >= 1);
         check("busy", busy_out, m_active);
         check("done", done_out, m_done);
         check("error", error_out, m_err);
         check("owner", owner_out, m_active ? 1 : (m_done ? 2 : 0));
         check("merge_width", merge_width_out, m_w);
         check("src_bank", src_bank_out, m_src);
         check("pass_count", pass_count_out, m_pass);
         check("result_bank", result_bank_out, m_result);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_start(input int n);
      start_in = 1'b1;
      num_entries_in = CW'(n);
      tick();
      start_in = 1'b0;
      num_entries_in = CW'($urandom_range(0, ALL1));
   endtask

   task automatic pulse_done();
      phase_done_in = 1'b1;
      tick();
      phase_done_in = 1'b0;
   endtask

   task automatic run_sort(input int n, input bit noise, output int starts);
      int dly, cycles;
      starts = 0;
      cycles = 0;
      pulse_start(n);
      while (!(done_out || error_out) && cycles < 500) begin
         if (phase_start_out) starts++;
         if (phase_en_out && !phase_start_out) begin
            dly = $urandom_range(0, 4);
            for (int i = 0; i < dly; i++) begin
               if (noise) begin
                  start_in = 1'($urandom_range(0, 1));
                  num_entries_in = CW'($urandom_range(0, ALL1));
               end
               tick();
               cycles++;
            end
            start_in = 1'b0;
            pulse_done();
         end else begin
            tick();
         end
         cycles++;
      end
      if (cycles >= 500) fail_now("sort_wait");
   endtask

   initial begin
      int starts, cnt, pc;
      repeat (3) @(posedge clock);
      #1;
      check("rst_width", merge_width_out, SW);
      check("rst_owner", owner_out, 0);
      check("rst_busy", busy_out, 0);
      check("rst_en", phase_en_out, 0);
      @(negedge clock);
      reset_n = 1'b1;
      chk_en = 1'b1;
      tick();

      // two passes, result back in bank 0
      run_sort(64, 1'b1, starts);
      check("n64_starts", starts, 2);
      check("n64_pass", pass_count_out, 2);
      check("n64_result", result_bank_out, 0);
      check("n64_done", done_out, 1);
      check("n64_owner", owner_out, 2);

      // three passes, result in bank 1
      run_sort(100, 1'b1, starts);
      check("n100_starts", starts, 3);
      check("n100_pass", pass_count_out, 3);
      check("n100_result", result_bank_out, 1);
      check("n100_width", merge_width_out, 128);

      // launch latency and inter-pass gap, then abort in pass 2 together with done
      pulse_start(100);
      check("lat_check_cycle", phase_start_out, 0);
      tick();
      check("lat_first_issue", phase_start_out, 1);
      tick();
      tick();
      pulse_done();
      check("gap_check_cycle", phase_start_out, 0);
      tick();
      check("gap_issue", phase_start_out, 1);
      tick();
      abort_in = 1'b1;
      phase_done_in = 1'b1;
      tick();
      abort_in = 1'b0;
      phase_done_in = 1'b0;
      check("abort_en", phase_en_out, 0);
      check("abort_busy", busy_out, 0);
      check("abort_pass", pass_count_out, 1);
      check("abort_owner", owner_out, 0);

      // sorts that need no pass
      for (int k = 0; k < 2; k++) begin
         pulse_start(k == 0 ? 16 : 0);
         check("nopass_check_done", done_out, 0);
         check("nopass_check_start", phase_start_out, 0);
         tick();
         check("nopass_done", done_out, 1);
         check("nopass_start", phase_start_out, 0);
         check("nopass_pass", pass_count_out, 0);
         check("nopass_result", result_bank_out, 0);
      end

      // hung pass trips the watchdog
      pulse_start(40);
      tick();
      check("to_issue", phase_start_out, 1);
      cnt = 0;
      while (!error_out && cnt < 100) begin
         tick();
         cnt++;
      end
      check("to_cycles", cnt, TO);
      check("to_error", error_out, 1);
      check("to_en", phase_en_out, 0);
      check("to_owner", owner_out, 0);
      pulse_start(16);
      check("to_clear", error_out, 0);
      tick();
      check("to_restart_done", done_out, 1);

      // pass limit reached before width covers n
      run_sort(200, 1'b0, starts);
      check("limit_starts", starts, MP);
      check("limit_error", error_out, 1);
      check("limit_pass", pass_count_out, MP);

      // completions in IDLE are ignored
      abort_in = 1'b1;
      tick();
      abort_in = 1'b0;
      pc = int'(pass_count_out);
      repeat (3) pulse_done();
      check("idle_done_busy", busy_out, 0);
      check("idle_done_pass", pass_count_out, pc);

      // reset in the middle of a pass
      pulse_start(100);
      repeat (3) tick();
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_en", phase_en_out, 0);
      check("arst_busy", busy_out, 0);
      check("arst_width", merge_width_out, SW);
      check("arst_owner", owner_out, 0);
      check("arst_src", src_bank_out, 0);
      @(negedge clock);
      #1;
      reset_n = 1'b1;
      tick();

      // randomized sorts with noise and occasional aborts
      for (int r = 0; r < 30; r++) begin
         run_sort($urandom_range(0, 160), 1'b1, starts);
         repeat ($urandom_range(0, 3)) tick();
         if ($urandom_range(0, 3) == 0) begin
            abort_in = 1'b1;
            tick();
            abort_in = 1'b0;
         end
      end

      repeat (2) tick();
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
